// File: rtl/ip_codma_machine_states_pkg.sv
// Shared state encoding and CRC-16-CCITT constants for the codma CRC checker.
package ip_codma_machine_states_pkg;

    typedef enum logic [1:0] {
        CRC_IDLE  = 2'd0,
        CRC_CALC  = 2'd1,
        CRC_CHECK = 2'd2
    } crc_state_t;

    localparam logic [15:0] CRC16_CCITT_POLY = 16'h1021;
    localparam logic [15:0] CRC16_CCITT_INIT = 16'hFFFF;

    // Largest block the checker holds, in bytes.
    localparam logic [5:0] CRC_MAX_LEN = 6'd32;

    // A length of 0 means a full block; anything above the block size is clamped to it.
    function automatic logic [5:0] clamp_len(input logic [5:0] len);
        return ((len == 6'd0) || (len > CRC_MAX_LEN)) ? CRC_MAX_LEN : len;
    endfunction

endpackage

// File: rtl/ip_codma_crc16_byte.sv
// Combinational one-byte CRC-16 update, MSB first, no reflection.
module ip_codma_crc16_byte #(
    parameter logic [15:0] POLY = 16'h1021
) (
    input  logic [15:0] crc_in,
    input  logic [7:0]  byte_in,
    output logic [15:0] crc_out
);

    logic [15:0] crc;

    // Fold the byte into the high half, then run eight polynomial-division steps.
    always_comb begin
        // NOTE: crc is fully assigned before any conditional use, so no latch is inferred.
        crc = crc_in ^ {byte_in, 8'h00};
        for (int i = 0; i < 8; i++) begin
            crc = crc[15] ? ((crc << 1) ^ POLY) : (crc << 1);
        end
        crc_out = crc;
    end

endmodule

// File: rtl/ip_codma_crc_check.sv
// Captures a message block, folds one byte per cycle into a CRC-16 and
// compares the result against a received CRC.
module ip_codma_crc_check
    import ip_codma_machine_states_pkg::*;
#(
    parameter logic [15:0] CRC_POLY = CRC16_CCITT_POLY,
    parameter logic [15:0] CRC_INIT = CRC16_CCITT_INIT
) (
    input  logic             clk_i,
    input  logic             reset_n_i,
    input  logic             start_i,
    input  logic [7:0][31:0] data_reg,
    input  logic [5:0]       len_i,
    input  logic [15:0]      crc_rx_i,
    output logic             busy_o,
    output logic             crc_complete_flag,
    output logic             crc_ok_o,
    output logic             crc_err_o,
    output logic [15:0]      crc_output
);

    crc_state_t       state_q, state_d;
    logic [15:0]      crc_q, crc_d;
    logic [4:0]       idx_q, idx_d;
    logic [5:0]       cnt_q, cnt_d;
    logic [15:0]      out_crc_q, out_crc_d;
    logic             ok_q, ok_d;
    logic             err_q, err_d;
    logic             flag_q, flag_d;

    logic [7:0][31:0] data_q;
    logic [15:0]      rx_q;
    logic             capture;

    logic [7:0]       cur_byte;
    logic [15:0]      crc_next;

    // Byte k lives in word k/4, lane k%4.
    assign cur_byte = data_q[idx_q[4:2]][{idx_q[1:0], 3'b000} +: 8];

    ip_codma_crc16_byte #(
        .POLY (CRC_POLY)
    ) u_crc_byte (
        .crc_in  (crc_q),
        .byte_in (cur_byte),
        .crc_out (crc_next)
    );

    // Next-state and datapath decisions for the IDLE -> CALC -> CHECK sequence.
    always_comb begin
        state_d   = state_q;
        crc_d     = crc_q;
        idx_d     = idx_q;
        cnt_d     = cnt_q;
        out_crc_d = out_crc_q;
        ok_d      = ok_q;
        err_d     = err_q;
        flag_d    = 1'b0;
        capture   = 1'b0;

        unique case (state_q)
            CRC_IDLE: begin
                if (start_i) begin
                    capture = 1'b1;
                    crc_d   = CRC_INIT;
                    idx_d   = 5'd0;
                    cnt_d   = clamp_len(len_i);
                    state_d = CRC_CALC;
                end
            end
            CRC_CALC: begin
                crc_d = crc_next;
                idx_d = idx_q + 5'd1;
                cnt_d = cnt_q - 6'd1;
                if (cnt_q == 6'd1) begin
                    state_d = CRC_CHECK;
                end
            end
            CRC_CHECK: begin
                out_crc_d = crc_q;
                ok_d      = (crc_q == rx_q);
                err_d     = (crc_q != rx_q);
                flag_d    = 1'b1;
                state_d   = CRC_IDLE;
            end
            default: begin
                state_d = CRC_IDLE;
            end
        endcase
    end

    // Control and result registers, cleared asynchronously.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            // NOTE: non-blocking assignments keep every register updating from pre-edge values.
            state_q   <= CRC_IDLE;
            crc_q     <= CRC_INIT;
            idx_q     <= 5'd0;
            cnt_q     <= 6'd0;
            out_crc_q <= 16'h0000;
            ok_q      <= 1'b0;
            err_q     <= 1'b0;
            flag_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            crc_q     <= crc_d;
            idx_q     <= idx_d;
            cnt_q     <= cnt_d;
            out_crc_q <= out_crc_d;
            ok_q      <= ok_d;
            err_q     <= err_d;
            flag_q    <= flag_d;
        end
    end

    // Block payload and received CRC, loaded only when a start is accepted.
    always_ff @(posedge clk_i) begin
        // NOTE: payload storage has no reset; it is always loaded before it is read.
        if (capture) begin
            data_q <= data_reg;
            rx_q   <= crc_rx_i;
        end
    end

    assign busy_o            = (state_q != CRC_IDLE);
    assign crc_complete_flag = flag_q;
    assign crc_ok_o          = ok_q;
    assign crc_err_o         = err_q;
    assign crc_output        = out_crc_q;

endmodule

// File: doc/ip_codma_crc_check.md
IP_CODMA_CRC_CHECK -- requirements
Module: ip_codma_crc_check

Interface
REQ-001 Parameter: CRC_POLY, default 16'h1021, generator polynomial x^16+x^12+x^5+1 (CRC-16-CCITT), MSB-first.
REQ-002 Parameter: CRC_INIT, default 16'hFFFF, CRC register seed; no final XOR and no bit reflection.
REQ-003 clk_i  input  1  single clock; all state updates on its rising edge.
REQ-004 reset_n_i  input  1  asynchronous, active-low reset.
REQ-005 start_i  input  1  single-cycle request to check one block; honoured only in CRC_IDLE.
REQ-006 data_reg  input  [7:0][31:0]  message block; byte k = data_reg[k/4][8*(k%4)+7 : 8*(k%4)].
REQ-007 len_i  input  6  message length in bytes (1..32); value 0 means 32; values 33..63 are clamped to 32.
REQ-008 crc_rx_i  input  16  received CRC to verify against.
REQ-009 busy_o  output  1  high in every state except CRC_IDLE.
REQ-010 crc_complete_flag  output  1  one-cycle pulse when a result is valid.
REQ-011 crc_ok_o  output  1  computed CRC equals crc_rx_i; held until the next completion or reset.
REQ-012 crc_err_o  output  1  inverse of crc_ok_o when a result is valid; held until the next completion or reset.
REQ-013 crc_output  output  16  computed CRC of the last block; held until the next completion or reset.

Function
REQ-014 The FSM states shall be CRC_IDLE, CRC_CALC and CRC_CHECK; the state leaves CRC_IDLE only on start_i.
REQ-015 On the edge that samples start_i=1 in CRC_IDLE: capture data_reg, len_i and crc_rx_i into internal registers; load crc_reg with CRC_INIT; load byte index 0 and remaining count len; go to CRC_CALC.
REQ-016 In CRC_CALC: each edge shall fold one byte (index 0 upward) into crc_reg as 8 MSB-first polynomial-division steps; increment index; decrement count.
REQ-017 When the count reaches zero on an edge, the state shall become CRC_CHECK.
REQ-018 In CRC_CHECK on one edge: crc_output <= crc_reg; crc_ok_o <= (crc_reg == captured crc_rx_i); crc_err_o <= !ok; crc_complete_flag <= 1; state <= CRC_IDLE.
REQ-019 Latency: with start sampled at edge S, the block shall assert crc_complete_flag after edge S+len+1 for exactly one cycle.
REQ-020 start_i while busy_o=1 shall be ignored; it shall not be queued, and captured inputs shall not change.
REQ-021 Input changes after the capture edge shall not affect the result in progress.
REQ-022 Back-to-back: a start_i in the cycle crc_complete_flag is high shall be accepted, because the state is CRC_IDLE.
REQ-023 Bytes at index >= len shall never enter the CRC.
REQ-024 crc_ok_o, crc_err_o and crc_output shall change only on the CRC_CHECK edge or on reset.

Reset
REQ-025 Assertion of reset_n_i shall immediately force: state CRC_IDLE, busy_o 0, crc_complete_flag 0, crc_ok_o 0, crc_err_o 0, crc_output 16'h0000, crc_reg CRC_INIT, index 0, count 0.
REQ-026 Reset mid-operation shall abandon the block; no completion pulse shall follow release of reset.
REQ-027 After reset release, the first start_i shall be accepted on the next rising edge.

Structure
REQ-028 The enum crc_state_t (CRC_IDLE, CRC_CALC, CRC_CHECK) and the constants CRC16_CCITT_POLY and CRC16_CCITT_INIT shall live in ip_codma_machine_states_pkg.
REQ-029 One combinational sub-module, ip_codma_crc16_byte (inputs crc_in[15:0] and byte_in[7:0], output crc_out[15:0], parameter POLY), shall implement the per-byte update; the checker shall instantiate it once.
REQ-030 Sub-module algorithm: crc ^= byte<<8, then 8 iterations of (msb ? (crc<<1)^POLY : crc<<1), truncated to 16 bits.

Verification
REQ-031 Scenario: ASCII "123456789" (data_reg[0]=32'h34333231, data_reg[1]=32'h38373635, data_reg[2][7:0]=8'h39), len_i=9, crc_rx_i=16'h29B1 -> crc_output=16'h29B1, crc_ok_o=1, flag at S+10.
REQ-032 Scenario: same block with crc_rx_i=16'h29B0 -> crc_output=16'h29B1, crc_ok_o=0, crc_err_o=1.
REQ-033 Scenario: single byte 8'h00, len_i=1, crc_rx_i=16'hE1F0 -> crc_ok_o=1, flag at S+2; then len_i=0 with all-zero data_reg -> exactly 32 CALC cycles, flag at S+33.
REQ-034 Scenario: "123456789" followed by bytes 8'h29, 8'hB1 (len_i=11), crc_rx_i=16'h0000 -> crc_output=16'h0000 (zero residue), crc_ok_o=1.
REQ-035 Scenario: start_i re-pulsed and data_reg/crc_rx_i altered mid-CALC -> result identical to REQ-031 and exactly one flag pulse; start_i held high across completion -> second check begins the cycle the flag is high.
REQ-036 Scenario: reset_n_i asserted at S+4 of a 9-byte check -> all outputs at their reset values immediately, no flag after release, next check correct.
